// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite fanout: bus configuration, response codes
// and the state encodings of the read and write engines.
package axi4_lite_pkg;

  typedef struct packed {
    int unsigned A;
    int unsigned N;
  } axi4_lite_cfg_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} fanout_wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} fanout_rstate_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; the master modport drives requests, the slave modport
// drives handshakes and responses.
interface axi4_lite_if
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t C = '{A: 16, N: 4}
);
  logic               awvalid;
  logic               awready;
  logic [C.A-1:0]     awaddr;
  logic [2:0]         awprot;
  logic               wvalid;
  logic               wready;
  logic [8*C.N-1:0]   wdata;
  logic [C.N-1:0]     wstrb;
  logic               bvalid;
  logic               bready;
  logic [1:0]         bresp;
  logic               arvalid;
  logic               arready;
  logic [C.A-1:0]     araddr;
  logic [2:0]         arprot;
  logic               rvalid;
  logic               rready;
  logic [8*C.N-1:0]   rdata;
  logic [1:0]         rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_fanout_decode.sv
// Address window decoder: picks the downstream port owning an address and
// flags addresses that fall beyond the last window.
module axi4_lite_fanout_decode #(
  parameter int A  = 16,
  parameter int D  = 2,
  parameter int M  = 'h100,
  parameter int IW = $clog2(D)
) (
  input  logic [A-1:0]  addr,
  output logic [IW-1:0] idx,
  output logic          hit
);
  localparam int LM = $clog2(M);

  logic [A-1:0] window;

  assign window = addr >> LM;
  assign hit    = (window < A'(D));
  assign idx    = window[IW-1:0];

endmodule

// File: rtl/axi4_lite_bus_fanout.sv
// 1-to-D AXI4-Lite address splitter with independent registered read and
// write engines. Optional macro AXI4_LITE_BUS_FANOUT_DECERR_EN: when defined,
// unmapped addresses are answered locally with DECERR; otherwise they are
// routed to the last port.
module axi4_lite_bus_fanout
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t C = '{A: 16, N: 4},
  parameter int D = 2,
  parameter int M = 'h100
) (
  input  logic        aclk,
  input  logic        areset,
  axi4_lite_if.slave  axi4_s,
  axi4_lite_if.master axi4_m [D]
);
  localparam int AW = C.A;
  localparam int DW = 8 * C.N;
  localparam int SW = C.N;
  localparam int IW = $clog2(D);
  localparam logic [D-1:0] PORT0 = {{(D-1){1'b0}}, 1'b1};

  // downstream handshake/response signals gathered into indexable arrays
  logic [D-1:0]  dn_awready, dn_wready, dn_bvalid, dn_arready, dn_rvalid;
  logic [1:0]    dn_bresp [D];
  logic [1:0]    dn_rresp [D];
  logic [DW-1:0] dn_rdata [D];

  // write engine state
  fanout_wstate_t w_state, w_state_d;
  logic           awready_q, awready_d, wready_q, wready_d;
  logic           aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0]  awaddr_q, awaddr_d;
  logic [2:0]     awprot_q, awprot_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]  wstrb_q, wstrb_d;
  logic [IW-1:0]  w_idx_q, w_idx_d;
  logic [D-1:0]   w_sel_q, w_sel_d;
  logic           m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
  logic           m_bready_q, m_bready_d, bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;

  // read engine state
  fanout_rstate_t r_state, r_state_d;
  logic           arready_q, arready_d;
  logic [AW-1:0]  araddr_q, araddr_d;
  logic [2:0]     arprot_q, arprot_d;
  logic [IW-1:0]  r_idx_q, r_idx_d;
  logic [D-1:0]   r_sel_q, r_sel_d;
  logic           m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
  logic           rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic           aw_fire, w_fire, ar_fire;
  logic [AW-1:0]  w_dec_addr;
  logic [IW-1:0]  w_dec_idx, r_dec_idx, w_route_idx, r_route_idx;
  logic           w_dec_hit, r_dec_hit, w_route_ok, r_route_ok;

  assign aw_fire    = axi4_s.awvalid && awready_q;
  assign w_fire     = axi4_s.wvalid && wready_q;
  assign ar_fire    = axi4_s.arvalid && arready_q;
  assign w_dec_addr = aw_held_q ? awaddr_q : axi4_s.awaddr;

  axi4_lite_fanout_decode #(.A(AW), .D(D), .M(M), .IW(IW)) u_wdec (
    .addr (w_dec_addr),
    .idx  (w_dec_idx),
    .hit  (w_dec_hit)
  );

  axi4_lite_fanout_decode #(.A(AW), .D(D), .M(M), .IW(IW)) u_rdec (
    .addr (axi4_s.araddr),
    .idx  (r_dec_idx),
    .hit  (r_dec_hit)
  );

  // turn a decode into a target port, or mark a miss for local DECERR
  always_comb begin
`ifdef AXI4_LITE_BUS_FANOUT_DECERR_EN
    w_route_ok  = w_dec_hit;
    w_route_idx = w_dec_idx;
    r_route_ok  = r_dec_hit;
    r_route_idx = r_dec_idx;
`else
    w_route_ok  = 1'b1;
    w_route_idx = w_dec_hit ? w_dec_idx : IW'(D - 1);
    r_route_ok  = 1'b1;
    r_route_idx = r_dec_hit ? r_dec_idx : IW'(D - 1);
`endif
  end

  // write engine: capture AW/W, forward to the chosen port, relay B
  always_comb begin
    w_state_d   = w_state;
    awready_d   = awready_q;
    wready_d    = wready_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    awprot_d    = awprot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    w_idx_d     = w_idx_q;
    w_sel_d     = w_sel_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    case (w_state)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awready_d = 1'b0;
          awaddr_d  = axi4_s.awaddr;
          awprot_d  = axi4_s.awprot;
        end else if (!aw_held_q) begin
          awready_d = 1'b1;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wready_d = 1'b0;
          wdata_d  = axi4_s.wdata;
          wstrb_d  = axi4_s.wstrb;
        end else if (!w_held_q) begin
          wready_d = 1'b1;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          w_idx_d = w_route_idx;
          if (w_route_ok) begin
            w_state_d   = W_FWD;
            w_sel_d     = PORT0 << w_route_idx;
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
          end else begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = DECERR;
          end
        end
      end
      W_FWD: begin
        if (m_awvalid_q && dn_awready[w_idx_q]) m_awvalid_d = 1'b0;
        if (m_wvalid_q && dn_wready[w_idx_q])   m_wvalid_d  = 1'b0;
        if (!m_awvalid_d && !m_wvalid_d) begin
          w_state_d  = W_RESP;
          m_bready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (m_bready_q && dn_bvalid[w_idx_q]) begin
          m_bready_d = 1'b0;
          bresp_d    = dn_bresp[w_idx_q];
          bvalid_d   = 1'b1;
        end
        if (bvalid_q && axi4_s.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_sel_d   = '0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // write engine registers; reset drops every valid/ready and payload
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state     <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      w_idx_q     <= '0;
      w_sel_q     <= '0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
    end else begin
      w_state     <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      awprot_q    <= awprot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      w_idx_q     <= w_idx_d;
      w_sel_q     <= w_sel_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
    end
  end

  // read engine: capture AR, forward to the chosen port, relay R
  always_comb begin
    r_state_d   = r_state;
    arready_d   = arready_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    r_idx_d     = r_idx_q;
    r_sel_d     = r_sel_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    case (r_state)
      R_IDLE: begin
        if (ar_fire) begin
          arready_d = 1'b0;
          araddr_d  = axi4_s.araddr;
          arprot_d  = axi4_s.arprot;
          r_idx_d   = r_route_idx;
          if (r_route_ok) begin
            r_state_d   = R_FWD;
            r_sel_d     = PORT0 << r_route_idx;
            m_arvalid_d = 1'b1;
          end else begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rresp_d   = DECERR;
            rdata_d   = '0;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_FWD: begin
        if (m_arvalid_q && dn_arready[r_idx_q]) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          r_state_d   = R_RESP;
        end
      end
      R_RESP: begin
        if (m_rready_q && dn_rvalid[r_idx_q]) begin
          m_rready_d = 1'b0;
          rdata_d    = dn_rdata[r_idx_q];
          rresp_d    = dn_rresp[r_idx_q];
          rvalid_d   = 1'b1;
        end
        if (rvalid_q && axi4_s.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          r_sel_d   = '0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // read engine registers; reset abandons any read in flight
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= R_IDLE;
      arready_q   <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      r_idx_q     <= '0;
      r_sel_q     <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
    end else begin
      r_state     <= r_state_d;
      arready_q   <= arready_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      r_idx_q     <= r_idx_d;
      r_sel_q     <= r_sel_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  // upstream outputs come straight from the engine registers
  assign axi4_s.awready = awready_q;
  assign axi4_s.wready  = wready_q;
  assign axi4_s.bvalid  = bvalid_q;
  assign axi4_s.bresp   = bresp_q;
  assign axi4_s.arready = arready_q;
  assign axi4_s.rvalid  = rvalid_q;
  assign axi4_s.rdata   = rdata_q;
  assign axi4_s.rresp   = rresp_q;

  // only the selected port sees valids, readies or payload
  for (genvar k = 0; k < D; k++) begin : g_port
    assign axi4_m[k].awvalid = m_awvalid_q & w_sel_q[k];
    assign axi4_m[k].awaddr  = w_sel_q[k] ? awaddr_q : '0;
    assign axi4_m[k].awprot  = w_sel_q[k] ? awprot_q : '0;
    assign axi4_m[k].wvalid  = m_wvalid_q & w_sel_q[k];
    assign axi4_m[k].wdata   = w_sel_q[k] ? wdata_q : '0;
    assign axi4_m[k].wstrb   = w_sel_q[k] ? wstrb_q : '0;
    assign axi4_m[k].bready  = m_bready_q & w_sel_q[k];
    assign axi4_m[k].arvalid = m_arvalid_q & r_sel_q[k];
    assign axi4_m[k].araddr  = r_sel_q[k] ? araddr_q : '0;
    assign axi4_m[k].arprot  = r_sel_q[k] ? arprot_q : '0;
    assign axi4_m[k].rready  = m_rready_q & r_sel_q[k];

    assign dn_awready[k] = axi4_m[k].awready;
    assign dn_wready[k]  = axi4_m[k].wready;
    assign dn_bvalid[k]  = axi4_m[k].bvalid;
    assign dn_bresp[k]   = axi4_m[k].bresp;
    assign dn_arready[k] = axi4_m[k].arready;
    assign dn_rvalid[k]  = axi4_m[k].rvalid;
    assign dn_rdata[k]   = axi4_m[k].rdata;
    assign dn_rresp[k]   = axi4_m[k].rresp;
  end

endmodule

// File: tb/tb_axi4_lite_bus_fanout.sv
// Directed bench for axi4_lite_bus_fanout with four register-file stubs.
module tb_axi4_lite_bus_fanout;
  import axi4_lite_pkg::*;

  localparam axi4_lite_cfg_t CFG = '{A: 16, N: 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [3:0]  arv, awv, wv;
  logic [31:0] rd;
  logic [1:0]  rr, br;
  int          hs_before;
  int          n;

  always #5 clk = ~clk;

  axi4_lite_if #(.C(CFG)) up ();
  axi4_lite_if #(.C(CFG)) dn [4] ();

  axi4_lite_bus_fanout #(.C(CFG), .D(4), .M('h100)) dut (
    .aclk   (clk),
    .areset (rst),
    .axi4_s (up),
    .axi4_m (dn)
  );

  // terminus stubs: always ready, fixed read data per port, OKAY responses
  for (genvar k = 0; k < 4; k++) begin : g_stub
    localparam logic [31:0] RVAL = (k == 0) ? 32'h1111_1111 :
                                   (k == 1) ? 32'h2222_2222 :
                                   (k == 2) ? 32'h3333_3333 : 32'hbbbb_bbbb;
    logic        aw_got, w_got;
    logic [15:0] last_awaddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;
    int          ar_hs, aw_hs;

    assign dn[k].awready = 1'b1;
    assign dn[k].wready  = 1'b1;
    assign dn[k].arready = 1'b1;
    assign dn[k].bresp   = 2'b00;
    assign dn[k].rresp   = 2'b00;
    assign arv[k] = dn[k].arvalid;
    assign awv[k] = dn[k].awvalid;
    assign wv[k]  = dn[k].wvalid;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        last_awaddr  <= '0;
        last_wdata   <= '0;
        last_wstrb   <= '0;
        ar_hs        <= 0;
        aw_hs        <= 0;
        dn[k].bvalid <= 1'b0;
        dn[k].rvalid <= 1'b0;
        dn[k].rdata  <= '0;
      end else begin
        if (dn[k].awvalid) begin
          aw_got      <= 1'b1;
          last_awaddr <= dn[k].awaddr;
          aw_hs       <= aw_hs + 1;
        end
        if (dn[k].wvalid) begin
          w_got      <= 1'b1;
          last_wdata <= dn[k].wdata;
          last_wstrb <= dn[k].wstrb;
        end
        if (aw_got && w_got) begin
          dn[k].bvalid <= 1'b1;
          aw_got       <= 1'b0;
          w_got        <= 1'b0;
        end else if (dn[k].bvalid && dn[k].bready) begin
          dn[k].bvalid <= 1'b0;
        end
        if (dn[k].arvalid) begin
          dn[k].rvalid <= 1'b1;
          dn[k].rdata  <= RVAL;
          ar_hs        <= ar_hs + 1;
        end else if (dn[k].rvalid && dn[k].rready) begin
          dn[k].rvalid <= 1'b0;
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timed_out(input string tag);
    total++;
    bad++;
    $display("[TB] FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // all stimulus tasks start and end on a falling edge
  task automatic send_ar(input logic [15:0] addr);
    int k = 0;
    up.araddr  = addr;
    up.arprot  = 3'b000;
    up.arvalid = 1'b1;
    while (!up.arready && k < 20) begin @(negedge clk); k++; end
    if (!up.arready) timed_out("ar_handshake");
    @(posedge clk); #1;
    up.arvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_aw(input logic [15:0] addr);
    int k = 0;
    up.awaddr  = addr;
    up.awprot  = 3'b000;
    up.awvalid = 1'b1;
    while (!up.awready && k < 20) begin @(negedge clk); k++; end
    if (!up.awready) timed_out("aw_handshake");
    @(posedge clk); #1;
    up.awvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int k = 0;
    up.wdata  = data;
    up.wstrb  = strb;
    up.wvalid = 1'b1;
    while (!up.wready && k < 20) begin @(negedge clk); k++; end
    if (!up.wready) timed_out("w_handshake");
    @(posedge clk); #1;
    up.wvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_stimulus_resp(input bit want_r, input bit want_b,
                                     output logic [31:0] rdata, output logic [1:0] rresp,
                                     output logic [1:0] bresp);
    bit got_r = !want_r;
    bit got_b = !want_b;
    int k = 0;
    rdata = '0;
    rresp = '0;
    bresp = '0;
    up.rready = want_r;
    up.bready = want_b;
    while (k < 30) begin
      if (!got_r && up.rvalid) begin rdata = up.rdata; rresp = up.rresp; got_r = 1'b1; end
      if (!got_b && up.bvalid) begin bresp = up.bresp; got_b = 1'b1; end
      if (got_r && got_b) break;
      @(negedge clk);
      k++;
    end
    if (!got_r) timed_out("r_response");
    if (!got_b) timed_out("b_response");
    @(posedge clk); #1;
    up.rready = 1'b0;
    up.bready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    up.awvalid = 1'b0; up.awaddr = '0; up.awprot = '0;
    up.wvalid  = 1'b0; up.wdata  = '0; up.wstrb  = '0;
    up.bready  = 1'b0;
    up.arvalid = 1'b0; up.araddr = '0; up.arprot = '0;
    up.rready  = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    check_output("reset_awready", up.awready, 0);
    check_output("reset_wready",  up.wready,  0);
    check_output("reset_arready", up.arready, 0);
    check_output("reset_bvalid",  up.bvalid,  0);
    check_output("reset_rvalid",  up.rvalid,  0);
    check_output("reset_dn_valid", {arv, awv, wv}, 0);

    rst = 1'b0;
    @(negedge clk);
    check_output("release_arready", up.arready, 1);
    check_output("release_awready", up.awready, 1);
    check_output("release_wready",  up.wready,  1);

    // read 0x004 -> port 0 only
    send_ar(16'h0004);
    check_output("rd004_arvalid_vec", arv, 4'b0001);
    check_output("rd004_araddr_p0", dn[0].araddr, 16'h0004);
    check_output("rd004_araddr_p1_zero", dn[1].araddr, 16'h0000);
    apply_stimulus_resp(1'b1, 1'b0, rd, rr, br);
    check_output("rd004_rdata", rd, 32'h1111_1111);
    check_output("rd004_rresp", rr, OKAY);

    // window edges: 0x1FC is port 1, 0x200 is port 2
    send_ar(16'h01fc);
    check_output("rd1fc_arvalid_vec", arv, 4'b0010);
    apply_stimulus_resp(1'b1, 1'b0, rd, rr, br);
    check_output("rd1fc_rdata", rd, 32'h2222_2222);
    send_ar(16'h0200);
    check_output("rd200_arvalid_vec", arv, 4'b0100);
    apply_stimulus_resp(1'b1, 1'b0, rd, rr, br);
    check_output("rd200_rdata", rd, 32'h3333_3333);

    // write 0x304 with W arriving well before AW
    send_w(32'habba_beef, 4'hf);
    check_output("wr304_wready_after_w", up.wready, 0);
    check_output("wr304_awready_after_w", up.awready, 1);
    check_output("wr304_no_early_fwd", {awv, wv}, 0);
    repeat (3) @(negedge clk);
    send_aw(16'h0304);
    check_output("wr304_awvalid_vec", awv, 4'b1000);
    check_output("wr304_wvalid_vec", wv, 4'b1000);
    apply_stimulus_resp(1'b0, 1'b1, rd, rr, br);
    check_output("wr304_bresp", br, OKAY);
    check_output("wr304_awaddr", g_stub[3].last_awaddr, 16'h0304);
    check_output("wr304_wdata", g_stub[3].last_wdata, 32'habba_beef);
    check_output("wr304_wstrb", g_stub[3].last_wstrb, 4'hf);

    // read 0x400, outside all windows
    hs_before = g_stub[0].ar_hs + g_stub[1].ar_hs + g_stub[2].ar_hs + g_stub[3].ar_hs;
    send_ar(16'h0400);
`ifdef AXI4_LITE_BUS_FANOUT_DECERR_EN
    check_output("rd400_no_dn_valid", arv, 4'b0000);
    check_output("rd400_miss_latency", up.rvalid, 1);
    apply_stimulus_resp(1'b1, 1'b0, rd, rr, br);
    check_output("rd400_rresp", rr, DECERR);
    check_output("rd400_rdata", rd, 32'h0);
    check_output("rd400_dn_handshakes",
                 g_stub[0].ar_hs + g_stub[1].ar_hs + g_stub[2].ar_hs + g_stub[3].ar_hs, hs_before);
`else
    check_output("rd400_arvalid_vec", arv, 4'b1000);
    apply_stimulus_resp(1'b1, 1'b0, rd, rr, br);
    check_output("rd400_rresp", rr, OKAY);
    check_output("rd400_rdata", rd, 32'hbbbb_bbbb);
    check_output("rd400_dn_handshakes",
                 g_stub[0].ar_hs + g_stub[1].ar_hs + g_stub[2].ar_hs + g_stub[3].ar_hs, hs_before + 1);
`endif

    // concurrent read 0x010 and write 0x208
    hs_before = g_stub[0].aw_hs;
    up.araddr = 16'h0010; up.arvalid = 1'b1;
    up.awaddr = 16'h0208; up.awvalid = 1'b1;
    up.wdata  = 32'hcafe_0208; up.wstrb = 4'h3; up.wvalid = 1'b1;
    n = 0;
    while (!(up.arready && up.awready && up.wready) && n < 20) begin @(negedge clk); n++; end
    if (!(up.arready && up.awready && up.wready)) timed_out("dual_handshake");
    @(posedge clk); #1;
    up.arvalid = 1'b0; up.awvalid = 1'b0; up.wvalid = 1'b0;
    @(negedge clk);
    check_output("dual_arvalid_vec", arv, 4'b0001);
    check_output("dual_awvalid_vec", awv, 4'b0100);
    check_output("dual_wvalid_vec", wv, 4'b0100);
    apply_stimulus_resp(1'b1, 1'b1, rd, rr, br);
    check_output("dual_rdata", rd, 32'h1111_1111);
    check_output("dual_bresp", br, OKAY);
    check_output("dual_awaddr_p2", g_stub[2].last_awaddr, 16'h0208);
    check_output("dual_wdata_p2", g_stub[2].last_wdata, 32'hcafe_0208);
    check_output("dual_wstrb_p2", g_stub[2].last_wstrb, 4'h3);
    check_output("dual_no_aw_p0", g_stub[0].aw_hs, hs_before);

    // reset while a read response is waiting on rready
    send_ar(16'h0104);
    n = 0;
    while (!up.rvalid && n < 20) begin @(negedge clk); n++; end
    check_output("rst_rvalid_pending", up.rvalid, 1);
    #1 rst = 1'b1;
    #1;
    check_output("rst_rvalid_dropped", up.rvalid, 0);
    check_output("rst_arready_dropped", up.arready, 0);
    check_output("rst_rdata_cleared", up.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_arready_back", up.arready, 1);
    send_ar(16'h0104);
    check_output("rd104_arvalid_vec", arv, 4'b0010);
    apply_stimulus_resp(1'b1, 1'b0, rd, rr, br);
    check_output("rd104_rdata", rd, 32'h2222_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
